// File: rtl/cycle_stat_display.sv
// Cycle-statistics reader: selects a counter, snapshots it, scans 8 seven-segment digits.
// Define STAT_DISP_DEC_EN for decimal (BCD) display instead of raw hex.
module cycle_stat_display #(
  parameter int REFRESH_CYCLES  = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SAMPLE_CYCLES   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_cycle,
  input  logic [31:0] cobranch_cycle,
  input  logic [31:0] unbranch_cycle,
  input  logic        sel_btn,
  input  logic        freeze,
  output logic [1:0]  cur_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  logic          btn_s1;
  logic          btn_s2;
  logic          btn_stable;
  logic          btn_stable_q;
  logic [DW-1:0] db_cnt;
  logic          press;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_stable   <= 1'b0;
      btn_stable_q <= 1'b0;
      db_cnt       <= '0;
    end else begin
      btn_s1       <= sel_btn;
      btn_s2       <= btn_s1;
      btn_stable_q <= btn_stable;
      if (btn_s2 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable <= ~btn_stable;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_stable & ~btn_stable_q;

  logic [SW-1:0] smp_cnt;
  logic          smp_tc;
  logic          reload_pend;
  logic          load;
  logic [31:0]   sel_val;
  logic [31:0]   snapshot;

  always_comb begin
    sel_val = total_cycle;
    case (cur_sel)
      2'd1:    sel_val = cobranch_cycle;
      2'd2:    sel_val = unbranch_cycle;
      default: sel_val = total_cycle;
    endcase
  end

  assign smp_tc = (smp_cnt == SW'(SAMPLE_CYCLES - 1));
  // A press at terminal count defers to the forced reload of the new source.
  assign load = reload_pend | (smp_tc & ~freeze & ~press);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel     <= 2'd0;
      reload_pend <= 1'b0;
      smp_cnt     <= '0;
      snapshot    <= '0;
    end else begin
      if (press)
        cur_sel <= (cur_sel == 2'd2) ? 2'd0 : cur_sel + 2'd1;
      reload_pend <= press;
      if (reload_pend | smp_tc)
        smp_cnt <= '0;
      else
        smp_cnt <= smp_cnt + 1'b1;
      if (load)
        snapshot <= sel_val;
    end
  end

  logic [31:0] disp_val;
  logic        dp_all;

`ifdef STAT_DISP_DEC_EN
  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_DONE
  } cv_state_t;

  cv_state_t   cv_state;
  cv_state_t   cv_next;
  logic        cv_start;
  logic        cv_shift;
  logic        cv_done;
  logic [31:0] cv_src;
  logic [39:0] cv_work;
  logic [35:0] cv_adj;
  logic [4:0]  cv_bit;
  logic [31:0] bcd;
  logic        bcd_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_start <= 1'b0;
      cv_state <= CV_IDLE;
    end else begin
      cv_start <= load;
      cv_state <= cv_next;
    end
  end

  always_comb begin
    cv_next = cv_state;
    if (cv_start) begin
      cv_next = CV_SHIFT;
    end else begin
      case (cv_state)
        CV_SHIFT: if (cv_bit == 5'd31) cv_next = CV_DONE;
        CV_DONE:  cv_next = CV_IDLE;
        default:  cv_next = CV_IDLE;
      endcase
    end
  end

  always_comb begin
    cv_shift = (cv_state == CV_SHIFT) & ~cv_start;
    cv_done  = (cv_state == CV_DONE) & ~cv_start;
  end

  // Top BCD digit never exceeds 4 for a 32-bit value, so it needs no add-3.
  always_comb begin
    cv_adj = '0;
    for (int i = 0; i < 9; i++) begin
      if (cv_work[4*i +: 4] >= 4'd5)
        cv_adj[4*i +: 4] = cv_work[4*i +: 4] + 4'd3;
      else
        cv_adj[4*i +: 4] = cv_work[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_src   <= '0;
      cv_work  <= '0;
      cv_bit   <= '0;
      bcd      <= '0;
      bcd_over <= 1'b0;
    end else if (cv_start) begin
      cv_src  <= snapshot;
      cv_work <= '0;
      cv_bit  <= '0;
    end else if (cv_shift) begin
      cv_work <= {cv_work[38:36], cv_adj, cv_src[31]};
      cv_src  <= {cv_src[30:0], 1'b0};
      cv_bit  <= cv_bit + 5'd1;
    end else if (cv_done) begin
      bcd      <= cv_work[31:0];
      bcd_over <= |cv_work[39:32];
    end
  end

  assign disp_val = bcd;
  assign dp_all   = bcd_over;
`else
  assign disp_val = snapshot;
  assign dp_all   = 1'b0;
`endif

  logic [RW-1:0] ref_cnt;
  logic [2:0]    digit;
  logic [3:0]    nib;
  logic          dp_on;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign nib   = disp_val[{digit, 2'b00} +: 4];
  assign dp_on = dp_all | (digit == {1'b0, cur_sel});

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      digit   <= 3'd0;
      an      <= 8'hFF;
      seg     <= 8'hFF;
    end else begin
      if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
        ref_cnt <= '0;
        digit   <= digit + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an  <= ~(8'd1 << digit);
      seg <= {~dp_on, ~hex7(nib)};
    end
  end

endmodule

// File: tb/tb_cycle_stat_display.sv
// Directed bench for cycle_stat_display with small timing parameters.
// Covers reset, scan, debounce, source select, freeze and reset-during-press.
module tb_cycle_stat_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] total_cycle;
  logic [31:0] cobranch_cycle;
  logic [31:0] unbranch_cycle;
  logic        sel_btn = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  cur_sel;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p0 = 0;
  logic mon_en = 1'b0;
  logic mon_bad = 1'b0;

  cycle_stat_display #(
    .REFRESH_CYCLES (4),
    .DEBOUNCE_CYCLES(3),
    .SAMPLE_CYCLES  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .total_cycle   (total_cycle),
    .cobranch_cycle(cobranch_cycle),
    .unbranch_cycle(unbranch_cycle),
    .sel_btn       (sel_btn),
    .freeze        (freeze),
    .cur_sel       (cur_sel),
    .an            (an),
    .seg           (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Any fully lit '8' digit while enabled means a superseded value was shown.
  always @(negedge clk)
    if (mon_en && seg[6:0] == 7'h00) mon_bad <= 1'b1;

  typedef struct {
    string       name;
    logic [31:0] tot;
    logic [7:0]  an_e;
    logic [7:0]  seg_e;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Wait for a fresh arrival of the given anode pattern.
  task automatic wait_an(input logic [7:0] tgt, input string name);
    int n = 0;
    while (an == tgt && n < 80) begin
      @(negedge clk);
      n++;
    end
    while (an != tgt && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual an %h required %h", name, an, tgt);
    end
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    sel_btn = 1'b1;
    p0 = cyc + 1;
    repeat (hold) @(negedge clk);
    sel_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"d0_8", 32'h12345678, 8'hFE, 8'h00};
    vt[1] = '{"d1_7", 32'h12345678, 8'hFD, 8'hF8};
    vt[2] = '{"d2_6", 32'h12345678, 8'hFB, 8'h82};
    vt[3] = '{"d3_5", 32'h12345678, 8'hF7, 8'h92};
    vt[4] = '{"d4_4", 32'h12345678, 8'hEF, 8'h99};
    vt[5] = '{"d5_3", 32'h12345678, 8'hDF, 8'hB0};
    vt[6] = '{"d6_2", 32'h12345678, 8'hBF, 8'hA4};
    vt[7] = '{"d7_1", 32'h12345678, 8'h7F, 8'hF9};

    total_cycle    = 32'h12345678;
    cobranch_cycle = 32'hABCDEF07;
    unbranch_cycle = 32'h000000C5;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", cur_sel, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", an, 8'hFE);
    chk("first_seg", seg, 8'h40);

`ifdef STAT_DISP_DEC_EN
    freeze = 1'b1;
    cobranch_cycle = 32'd1234;
    press(6);
    chk("dec_sel1", cur_sel, 2'd1);
    repeat (40) @(negedge clk);
    wait_an(8'hFE, "dec_w0");
    chk("dec_1234_d0", seg, 8'h99);
    wait_an(8'hFD, "dec_w1");
    chk("dec_1234_d1", seg, 8'h30);
    wait_an(8'hF7, "dec_w3");
    chk("dec_1234_d3", seg, 8'hF9);
    wait_an(8'hEF, "dec_w4");
    chk("dec_1234_d4", seg, 8'hC0);

    unbranch_cycle = 32'hFFFFFFFF;
    press(6);
    repeat (40) @(negedge clk);
    wait_an(8'hFE, "dec_w0b");
    chk("dec_max_d0", seg, 8'h12);
    wait_an(8'hFD, "dec_w1b");
    chk("dec_max_d1", seg, 8'h10);
    wait_an(8'hFB, "dec_w2b");
    chk("dec_max_d2", seg, 8'h24);
    wait_an(8'h7F, "dec_w7b");
    chk("dec_max_d7", seg, 8'h10);

    total_cycle = 32'd8888;
    cobranch_cycle = 32'd5555;
    mon_en = 1'b1;
    press(6);
    press(6);
    repeat (45) @(negedge clk);
    mon_en = 1'b0;
    chk("dec_restart_sel", cur_sel, 2'd1);
    chk("dec_no_stale", mon_bad, 1'b0);
    wait_an(8'hFE, "dec_w0c");
    chk("dec_5555_d0", seg, 8'h92);
    wait_an(8'hFD, "dec_w1c");
    chk("dec_5555_d1", seg, 8'h12);
    wait_an(8'hEF, "dec_w4c");
    chk("dec_5555_d4", seg, 8'hC0);
`else
    repeat (20) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      total_cycle = vt[i].tot;
      wait_an(vt[i].an_e, vt[i].name);
      chk(vt[i].name, seg, vt[i].seg_e);
    end

    begin
      int n = 0;
      wait_an(8'hFE, "dwell_w");
      while (an == 8'hFE && n < 10) begin
        n++;
        @(negedge clk);
      end
      chk("dwell", n, 4);
    end

    press(2);
    chk("glitch_sel", cur_sel, 2'd0);
    press(6);
    chk("press1_sel", cur_sel, 2'd1);
    wait_an(8'hFE, "cob_w0");
    chk("cob_d0", seg, 8'hF8);
    wait_an(8'hFD, "cob_w1");
    chk("cob_d1_dp", seg, 8'h40);

    press(6);
    chk("press2_sel", cur_sel, 2'd2);
    wait_an(8'hFB, "unb_w2");
    chk("unb_d2_dp", seg, 8'h40);
    wait_an(8'hFD, "unb_w1");
    chk("unb_d1", seg, 8'hC6);

    // Align the next press pulse with a sample terminal count.
    begin
      logic bad = 1'b0;
      while (((cyc + 1 - p0) % 16) != 1 || (cyc + 1 - p0) < 17)
        @(negedge clk);
      unbranch_cycle = 32'hEEEEEEEE;
      sel_btn = 1'b1;
      p0 = cyc + 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (i == 5) sel_btn = 1'b0;
        if (seg[6:0] == 7'h06) bad = 1'b1;
      end
      chk("coinc_no_old", bad, 1'b0);
      chk("coinc_sel", cur_sel, 2'd0);
      wait_an(8'hFE, "coinc_w0");
      chk("coinc_new_d0", seg, 8'h00);
    end

    total_cycle = 32'd5;
    repeat (20) @(negedge clk);
    wait_an(8'hFE, "frz_w0");
    chk("frz_load5", seg, 8'h12);
    freeze = 1'b1;
    total_cycle = 32'd9;
    repeat (52) @(negedge clk);
    wait_an(8'hFE, "frz_w1");
    chk("frz_hold5", seg, 8'h12);
    press(6);
    chk("frz_press_sel", cur_sel, 2'd1);
    wait_an(8'hFE, "frz_w2");
    chk("frz_press_load", seg, 8'hF8);
    cobranch_cycle = 32'd3;
    repeat (40) @(negedge clk);
    wait_an(8'hFE, "frz_w3");
    chk("frz_hold7", seg, 8'hF8);
    freeze = 1'b0;
    repeat (20) @(negedge clk);
    wait_an(8'hFE, "unfrz_w0");
    chk("unfrz_d0", seg, 8'hB0);
    wait_an(8'hFD, "unfrz_w1");
    chk("unfrz_d1_dp", seg, 8'h40);

    wait_an(8'hDF, "mid_w5");
    sel_btn = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sel_btn = 1'b0;
    @(negedge clk);
    chk("mid_rst_an", an, 8'hFF);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_sel", cur_sel, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", an, 8'hFE);
    chk("post_rst_seg", seg, 8'h40);
    repeat (2) @(negedge clk);
    chk("post_rst_snap", seg, 8'h40);
    repeat (20) @(negedge clk);
    chk("no_late_press", cur_sel, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
